// File: rtl/risc16_pkg.sv
// Shared RISC16 definitions: datapath widths, default reset PC and the
// fetch FSM state encoding.
package risc16_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection for the fetch unit: redirect target, sequential step,
// or hold. Redirect always wins; step arithmetic wraps modulo 2^16.
module fetch_pc_sel
  import risc16_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_STEP = 16'h0001
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] next_pc
);

  // Priority mux: redirect > step > hold
  always_comb begin
    next_pc = pc;
    if (redirect_valid)
      next_pc = redirect_pc;
    else if (advance)
      next_pc = pc + PC_STEP;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT FSM and the IF/ID
// pipeline register with a valid/ready handshake toward decode.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_count output,
// a wrapping count of instructions accepted by decode.
module fetch_unit
  import risc16_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [ADDR_W-1:0] PC_STEP  = 16'h0001
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              capture;  // load IF/ID from memory and step the PC
  logic              accept;   // decode consumes IF/ID (not flushed)

  // The memory address comes straight from the PC register
  assign imem_addr = pc;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // FSM next-state: redirect forces RUN, halt only leaves RUN
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (!redirect_valid && halt_req) state_nxt = HALT;
      HALT:    if (redirect_valid) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // FSM outputs: a redirect discards any capture or handshake this cycle
  always_comb begin
    capture = (state == RUN) && !redirect_valid && (!if_valid || if_ready);
    accept  = if_valid && if_ready && !redirect_valid;
  end

  fetch_pc_sel #(
    .PC_STEP(PC_STEP)
  ) u_pc_sel (
    .pc            (pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .advance       (capture),
    .next_pc       (pc_nxt)
  );

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_nxt;
  end

  // IF/ID register: flush on redirect, refill on capture, drain on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (capture) begin
      if_valid <= 1'b1;
      if_instr <= imem_data;
      if_pc    <= pc;
    end else if (accept) begin
      // Only reachable outside RUN (HALT drain); RUN accepts via capture
      if_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Count decode acceptances; flushed entries are never counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fetch_count <= '0;
    else if (accept) fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes each instruction it
// expects decode to accept; a negedge monitor pops and compares on every
// real handshake. Direct checks cover reset, stall, flush, wrap and halt.
module tb_fetch_unit;
  import risc16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Instruction memory: word at address a is 16'hA000 + a
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every real handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_accept: got pc %h, expected no acceptance", if_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("accept_pc", if_pc, e.pc);
        chk("accept_instr", if_instr, e.instr);
      end
    end
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 16'h0000; halt_req = 1'b0;
    #3;
    chk("rst_valid", {15'd0, if_valid}, 16'h0000);
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);

    // Release reset; A0 and A1 will be accepted
    step();
    rst_n = 1'b1; if_ready = 1'b1;
    push(16'h0000); push(16'h0001);
    step();  // BOOT
    chk("boot_valid", {15'd0, if_valid}, 16'h0000);
    chk("boot_addr", imem_addr, 16'h0000);
    step();
    chk("first_valid", {15'd0, if_valid}, 16'h0001);
    chk("first_instr", if_instr, 16'hA000);
    chk("first_pc", if_pc, 16'h0000);
    chk("first_addr", imem_addr, 16'h0001);
    step();
    chk("second_instr", if_instr, 16'hA001);
    chk("second_pc", if_pc, 16'h0001);
    if_ready = 1'b0;

    // Stall three cycles on A1
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", if_instr, 16'hA001);
      chk("stall_pc", if_pc, 16'h0001);
      chk("stall_addr", imem_addr, 16'h0002);
      chk("stall_valid", {15'd0, if_valid}, 16'h0001);
    end
    if_ready = 1'b1;
    step();
    chk("unstall_instr", if_instr, 16'hA002);
    chk("unstall_pc", if_pc, 16'h0002);

    // Redirect while stalled: A2 is flushed
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    chk("flush_valid", {15'd0, if_valid}, 16'h0000);
    chk("flush_addr", imem_addr, 16'h0040);
    redirect_valid = 1'b0; if_ready = 1'b1;
    push(16'h0040);
    step();
    chk("redir_pc", if_pc, 16'h0040);
    chk("redir_valid", {15'd0, if_valid}, 16'h0001);
    step();
    chk("redir_next_pc", if_pc, 16'h0041);

    // Redirect with a handshake pending: 0x41 is discarded
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    step();
    chk("wrap_flush_valid", {15'd0, if_valid}, 16'h0000);
    chk("wrap_addr", imem_addr, 16'hFFFE);
    redirect_valid = 1'b0;
    push(16'hFFFE); push(16'hFFFF);
    step();
    chk("wrap_pc_fffe", if_pc, 16'hFFFE);
    step();
    chk("wrap_pc_ffff", if_pc, 16'hFFFF);
    chk("wrap_addr_0", imem_addr, 16'h0000);
    step();
    chk("wrap_pc_0", if_pc, 16'h0000);
    chk("wrap_instr_0", if_instr, 16'hA000);
    chk("wrap_addr_1", imem_addr, 16'h0001);

    // halt_req and redirect together: redirect wins, 0x0000 flushed
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0010;
    step();
    chk("hr_valid", {15'd0, if_valid}, 16'h0000);
    chk("hr_addr", imem_addr, 16'h0010);
    halt_req = 1'b0; redirect_valid = 1'b0;
    push(16'h0010);
    step();
    chk("hr_pc", if_pc, 16'h0010);
    chk("hr_next_addr", imem_addr, 16'h0011);

    // halt_req alone while stalled -> HALT, PC frozen
    halt_req = 1'b1; if_ready = 1'b0;
    step();
    halt_req = 1'b0;
    chk("halt_pc", if_pc, 16'h0010);
    chk("halt_addr", imem_addr, 16'h0011);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halt_hold_addr", imem_addr, 16'h0011);
      chk("halt_hold_valid", {15'd0, if_valid}, 16'h0001);
    end
    if_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halt_drain_valid", {15'd0, if_valid}, 16'h0000);
      chk("halt_drain_addr", imem_addr, 16'h0011);
    end

    // Only a redirect leaves HALT
    redirect_valid = 1'b1; redirect_pc = 16'h0020;
    push(16'h0020);
    step();
    chk("unhalt_addr", imem_addr, 16'h0020);
    chk("unhalt_valid", {15'd0, if_valid}, 16'h0000);
    redirect_valid = 1'b0;
    step();
    chk("unhalt_pc", if_pc, 16'h0020);
    chk("unhalt_vld", {15'd0, if_valid}, 16'h0001);
    step();
    chk("unhalt_next_pc", if_pc, 16'h0021);
    if_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_count", fetch_count, 16'd7);
`endif

    // Mid-stream reset pulse acts immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {15'd0, if_valid}, 16'h0000);
    chk("async_rst_addr", imem_addr, 16'h0000);
    chk("async_rst_pc", if_pc, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    chk("async_rst_count", fetch_count, 16'd0);
`endif

    // Redirect during BOOT is honoured
    step();
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0030; if_ready = 1'b1;
    step();
    chk("boot_redir_addr", imem_addr, 16'h0030);
    chk("boot_redir_valid", {15'd0, if_valid}, 16'h0000);
    redirect_valid = 1'b0;
    push(16'h0030);
    step();
    chk("boot_redir_pc", if_pc, 16'h0030);
    step();
    chk("boot_redir_next", if_pc, 16'h0031);
    if_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_after_rst", fetch_count, 16'd1);
`endif
    step();
    chk("sb_empty", 16'(sb.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
